// File: rtl/sim_ram_dp.sv
// sim_ram_dp: true dual-port SRAM simulation model with byte-lane write masks,
// a configurable read-latency pipeline, read-during-write policy selection and
// defined collision / out-of-range behaviour.
module sim_ram_dp #(
    parameter int DP           = 512,
    parameter int DW           = 32,
    parameter int MW           = 4,
    parameter int AW           = 32,
    parameter int RD_LAT       = 1,
    parameter int RDW_MODE     = 0,
    parameter int FORCE_X2ZERO = 0,
    parameter int ITCM         = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req_valid,
    output logic          a_req_ready,
    input  logic          a_we,
    input  logic [MW-1:0] a_wem,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_din,
    output logic          a_rsp_valid,
    output logic [DW-1:0] a_rdata,
    output logic          a_err,
    input  logic          b_req_valid,
    output logic          b_req_ready,
    input  logic          b_we,
    input  logic [MW-1:0] b_wem,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_din,
    output logic          b_rsp_valid,
    output logic [DW-1:0] b_rdata,
    output logic          b_err
);

    localparam int IW = (DP > 1) ? $clog2(DP) : 1;
    // Clamp keeps the pipeline arrays well formed even when the latency check fires.
    localparam int NS = (RD_LAT >= 1 && RD_LAT <= 4) ? RD_LAT : 1;

    if (MW != (DW + 7) / 8) begin : g_badMaskWidth
        $error("sim_ram_dp: MW must equal ceil(DW/8)");
    end
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_badLatency
        $error("sim_ram_dp: RD_LAT must be in 1..4");
    end

    // Bit j belongs to byte lane j/8; a partial top lane simply has fewer bits.
    function automatic logic [DW-1:0] mergeLanes(input logic [DW-1:0] oldWord,
                                                 input logic [DW-1:0] newWord,
                                                 input logic [MW-1:0] mask);
        logic [DW-1:0] res;
        for (int j = 0; j < DW; j++) begin
            res[j] = mask[j/8] ? newWord[j] : oldWord[j];
        end
        return res;
    endfunction

    // Four-instruction LUI boot stub (lui x1..x4, 0) placed at words 0..3.
    function automatic logic [DW-1:0] bootWord(input logic [1:0] k);
        logic [31:0] w;
        case (k)
            2'd0:    w = 32'h0000_00B7;
            2'd1:    w = 32'h0000_0137;
            2'd2:    w = 32'h0000_01B7;
            default: w = 32'h0000_0237;
        endcase
        return DW'(w);
    endfunction

    logic [DW-1:0] r_mem [DP];
    logic          r_preloadDone = 1'b0;

    logic          r_aVld  [NS];
    logic          r_aErr  [NS];
    logic [DW-1:0] r_aData [NS];
    logic          r_bVld  [NS];
    logic          r_bErr  [NS];
    logic [DW-1:0] r_bData [NS];

    logic [IW-1:0] w_aIdx, w_bIdx;
    logic          w_aInRange, w_bInRange;
    logic          w_aRd, w_bRd, w_aWr, w_bWr, w_sameIdx;
    logic [DW-1:0] w_aOld, w_bOld, w_aWord, w_bWord, w_aRdWord, w_bRdWord;

    assign a_req_ready = ~rst;
    assign b_req_ready = ~rst;

    assign w_aIdx     = a_addr[IW-1:0];
    assign w_bIdx     = b_addr[IW-1:0];
    assign w_aInRange = 64'(a_addr) < 64'(DP);
    assign w_bInRange = 64'(b_addr) < 64'(DP);
    assign w_aRd      = a_req_valid & ~rst & ~a_we;
    assign w_bRd      = b_req_valid & ~rst & ~b_we;
    assign w_aWr      = a_req_valid & ~rst & a_we & w_aInRange;
    assign w_bWr      = b_req_valid & ~rst & b_we & w_bInRange;
    assign w_sameIdx  = (w_aIdx == w_bIdx);

    // Current word per port (boot stub visible before it lands), merged write words and read words.
    always_comb begin
        w_aOld = r_mem[w_aIdx];
        w_bOld = r_mem[w_bIdx];
        if (ITCM != 0 && !r_preloadDone) begin
            if (int'(w_aIdx) < 4) w_aOld = bootWord(2'(w_aIdx));
            if (int'(w_bIdx) < 4) w_bOld = bootWord(2'(w_bIdx));
        end
        w_bWord = mergeLanes(w_bOld, b_din, b_wem);
        w_aWord = (w_bWr && w_sameIdx) ? mergeLanes(w_bWord, a_din, a_wem)
                                       : mergeLanes(w_aOld, a_din, a_wem);
        w_aRdWord = '0;
        if (w_aInRange) begin
            w_aRdWord = (RDW_MODE != 0 && w_bWr && w_sameIdx) ? w_bWord : w_aOld;
        end
        w_bRdWord = '0;
        if (w_bInRange) begin
            w_bRdWord = (RDW_MODE != 0 && w_aWr && w_sameIdx)
                        ? mergeLanes(w_bOld, a_din, a_wem) : w_bOld;
        end
    end

    // Array update: boot stub once, then B, then A so A wins shared lanes on a collision.
    always_ff @(posedge clk) begin
        if (ITCM != 0 && !r_preloadDone) begin
            for (int k = 0; k < 4; k++) begin
                if (k < DP) r_mem[k] <= bootWord(2'(k));
            end
        end
        r_preloadDone <= 1'b1;
        if (w_bWr) r_mem[w_bIdx] <= w_bWord;
        if (w_aWr) r_mem[w_aIdx] <= w_aWord;
    end

    // Read pipelines; data only advances with a valid so the last stage holds rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                r_aVld[s]  <= 1'b0;
                r_aErr[s]  <= 1'b0;
                r_aData[s] <= '0;
                r_bVld[s]  <= 1'b0;
                r_bErr[s]  <= 1'b0;
                r_bData[s] <= '0;
            end
        end else begin
            r_aVld[0] <= w_aRd;
            r_aErr[0] <= w_aRd & ~w_aInRange;
            if (w_aRd) r_aData[0] <= w_aRdWord;
            r_bVld[0] <= w_bRd;
            r_bErr[0] <= w_bRd & ~w_bInRange;
            if (w_bRd) r_bData[0] <= w_bRdWord;
            for (int s = 1; s < NS; s++) begin
                r_aVld[s] <= r_aVld[s-1];
                r_aErr[s] <= r_aErr[s-1];
                if (r_aVld[s-1]) r_aData[s] <= r_aData[s-1];
                r_bVld[s] <= r_bVld[s-1];
                r_bErr[s] <= r_bErr[s-1];
                if (r_bVld[s-1]) r_bData[s] <= r_bData[s-1];
            end
        end
    end

    assign a_rsp_valid = r_aVld[NS-1];
    assign a_err       = r_aErr[NS-1];
    assign b_rsp_valid = r_bVld[NS-1];
    assign b_err       = r_bErr[NS-1];

    // Output data, optionally scrubbing unknown bits to zero in simulation builds.
    always_comb begin
        a_rdata = r_aData[NS-1];
        b_rdata = r_bData[NS-1];
`ifndef SYNTHESIS
        if (FORCE_X2ZERO != 0) begin
            for (int j = 0; j < DW; j++) begin
                if ($isunknown(r_aData[NS-1][j])) a_rdata[j] = 1'b0;
                if ($isunknown(r_bData[NS-1][j])) b_rdata[j] = 1'b0;
            end
        end
`endif
    end

endmodule

// File: tb/tb_sim_ram_dp.sv
// Testbench for sim_ram_dp: two instances (RD_LAT=1/read-first and
// RD_LAT=3/write-first) share one stimulus stream; a per-port scoreboard
// holds expected read responses with their due cycle.
module tb_sim_ram_dp;

    logic clk = 1'b0;
    logic rst;

    logic        aReqValid, aWe, bReqValid, bWe;
    logic [3:0]  aWem, bWem;
    logic [31:0] aAddr, aDin, bAddr, bDin;

    logic        aReqReady [2];
    logic        aRspValid [2];
    logic        aErr      [2];
    logic [31:0] aRdata    [2];
    logic        bReqReady [2];
    logic        bRspValid [2];
    logic        bErr      [2];
    logic [31:0] bRdata    [2];

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t        expQ [4][$];
    logic [31:0] lastData [4];
    string       portName [4] = '{"dut0.A", "dut0.B", "dut1.A", "dut1.B"};
    int          assertCount = 0;
    int          failCount = 0;
    int          cycleCnt = 0;
    logic        rstQ = 1'b0;
    logic        monEn = 1'b0;

    always #5 clk = ~clk;

    sim_ram_dp #(.RD_LAT(1), .RDW_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_req_valid(aReqValid), .a_req_ready(aReqReady[0]), .a_we(aWe), .a_wem(aWem),
        .a_addr(aAddr), .a_din(aDin), .a_rsp_valid(aRspValid[0]), .a_rdata(aRdata[0]), .a_err(aErr[0]),
        .b_req_valid(bReqValid), .b_req_ready(bReqReady[0]), .b_we(bWe), .b_wem(bWem),
        .b_addr(bAddr), .b_din(bDin), .b_rsp_valid(bRspValid[0]), .b_rdata(bRdata[0]), .b_err(bErr[0])
    );

    sim_ram_dp #(.RD_LAT(3), .RDW_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req_valid(aReqValid), .a_req_ready(aReqReady[1]), .a_we(aWe), .a_wem(aWem),
        .a_addr(aAddr), .a_din(aDin), .a_rsp_valid(aRspValid[1]), .a_rdata(aRdata[1]), .a_err(aErr[1]),
        .b_req_valid(bReqValid), .b_req_ready(bReqReady[1]), .b_we(bWe), .b_wem(bWem),
        .b_addr(bAddr), .b_din(bDin), .b_rsp_valid(bRspValid[1]), .b_rdata(bRdata[1]), .b_err(bErr[1])
    );

    // Edge counter and registered view of reset for the response monitor.
    always @(posedge clk) begin
        cycleCnt <= cycleCnt + 1;
        rstQ     <= rst;
    end

    // Scoreboard: pop and compare on every response, check holding and missed responses otherwise.
    always @(negedge clk) begin
        logic        v, e;
        logic [31:0] r;
        exp_t        ex;
        int          k;
        if (monEn) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    k = d * 2 + p;
                    v = (p == 0) ? aRspValid[d] : bRspValid[d];
                    e = (p == 0) ? aErr[d] : bErr[d];
                    r = (p == 0) ? aRdata[d] : bRdata[d];
                    if (rstQ) begin
                        expQ[k].delete();
                        lastData[k] = 32'h0;
                        assertCount++;
                        if (v !== 1'b0 || e !== 1'b0 || r !== 32'h0) begin
                            failCount++;
                            $display("[TB] FAIL %s reset outputs: got valid=%b err=%b rdata=%h, expected 0/0/00000000",
                                     portName[k], v, e, r);
                        end
                    end else if (v === 1'b1) begin
                        assertCount++;
                        if (expQ[k].size() == 0) begin
                            failCount++;
                            $display("[TB] FAIL %s unexpected response: got rdata=%h err=%b at cycle %0d, expected none",
                                     portName[k], r, e, cycleCnt);
                        end else begin
                            ex = expQ[k].pop_front();
                            if (r !== ex.data || e !== ex.err || cycleCnt != ex.due) begin
                                failCount++;
                                $display("[TB] FAIL %s response: got rdata=%h err=%b cycle=%0d, expected rdata=%h err=%b cycle=%0d",
                                         portName[k], r, e, cycleCnt, ex.data, ex.err, ex.due);
                            end
                        end
                        lastData[k] = r;
                    end else begin
                        assertCount++;
                        if (r !== lastData[k] || e !== 1'b0) begin
                            failCount++;
                            $display("[TB] FAIL %s idle hold: got rdata=%h err=%b, expected rdata=%h err=0",
                                     portName[k], r, e, lastData[k]);
                        end
                        if (expQ[k].size() != 0 && expQ[k][0].due <= cycleCnt) begin
                            ex = expQ[k].pop_front();
                            assertCount++;
                            failCount++;
                            $display("[TB] FAIL %s missing response: got none at cycle %0d, expected rdata=%h at cycle %0d",
                                     portName[k], cycleCnt, ex.data, ex.due);
                        end
                    end
                end
            end
        end
    end

    // Stimulus helpers.
    task automatic driveA(input logic v, input logic we, input logic [3:0] wem,
                          input logic [31:0] addr, input logic [31:0] din);
        aReqValid = v; aWe = we; aWem = wem; aAddr = addr; aDin = din;
    endtask

    task automatic driveB(input logic v, input logic we, input logic [3:0] wem,
                          input logic [31:0] addr, input logic [31:0] din);
        bReqValid = v; bWe = we; bWem = wem; bAddr = addr; bDin = din;
    endtask

    task automatic idle();
        driveA(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        driveB(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Push expectations for a read driven this cycle on port p (0=A, 1=B) for both DUTs.
    task automatic expectRead(input int p, input logic [31:0] d0, input logic [31:0] d1, input logic err);
        exp_t ex;
        ex.err  = err;
        ex.data = d0;
        ex.due  = cycleCnt + 1;
        expQ[p].push_back(ex);
        ex.data = d1;
        ex.due  = cycleCnt + 3;
        expQ[2 + p].push_back(ex);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (aReqReady[d] !== 1'b0 || bReqReady[d] !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset ready dut%0d: got a=%b b=%b, expected 0/0", d, aReqReady[d], bReqReady[d]);
            end
            assertCount++;
            if (aRspValid[d] !== 1'b0 || bRspValid[d] !== 1'b0 || aErr[d] !== 1'b0 || bErr[d] !== 1'b0
                || aRdata[d] !== 32'h0 || bRdata[d] !== 32'h0) begin
                failCount++;
                $display("[TB] FAIL reset outputs dut%0d: got valid=%b/%b err=%b/%b rdata=%h/%h, expected all 0",
                         d, aRspValid[d], bRspValid[d], aErr[d], bErr[d], aRdata[d], bRdata[d]);
            end
        end
        monEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (aReqReady[d] !== 1'b1 || bReqReady[d] !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL ready after reset dut%0d: got a=%b b=%b, expected 1/1", d, aReqReady[d], bReqReady[d]);
            end
        end
    endtask

    task automatic test_basic();
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd5, 32'hDEADBEEF);
        @(negedge clk); idle(); driveB(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
        expectRead(1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_byte_mask();
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd7, 32'h11223344);
        @(negedge clk); driveA(1'b1, 1'b1, 4'b0101, 32'd7, 32'hAABBCCDD);
        @(negedge clk); idle(); driveB(1'b1, 1'b0, 4'h0, 32'd7, 32'h0);
        expectRead(1, 32'h11BB33DD, 32'h11BB33DD, 1'b0);
        @(negedge clk); idle();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_collision();
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd9, 32'h0);
        @(negedge clk); driveA(1'b1, 1'b1, 4'b0001, 32'd9, 32'h000000AA);
        driveB(1'b1, 1'b1, 4'b0011, 32'd9, 32'h0000BBCC);
        @(negedge clk); idle(); driveA(1'b1, 1'b0, 4'h0, 32'd9, 32'h0);
        expectRead(0, 32'h0000BBAA, 32'h0000BBAA, 1'b0);
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_read_during_write();
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd2, 32'h00000001);
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd2, 32'h00000002);
        driveB(1'b1, 1'b0, 4'h0, 32'd2, 32'h0);
        expectRead(1, 32'h00000001, 32'h00000002, 1'b0);
        @(negedge clk); driveA(1'b1, 1'b1, 4'b0010, 32'd2, 32'h0000AB00);
        expectRead(1, 32'h00000002, 32'h0000AB02, 1'b0);
        @(negedge clk); driveA(1'b1, 1'b0, 4'h0, 32'd2, 32'h0);
        driveB(1'b1, 1'b1, 4'hF, 32'd2, 32'h00000033);
        expectRead(0, 32'h0000AB02, 32'h00000033, 1'b0);
        @(negedge clk); driveB(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        expectRead(0, 32'h00000033, 32'h00000033, 1'b0);
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd88, 32'h55667788);
        @(negedge clk); driveA(1'b1, 1'b1, 4'hF, 32'd600, 32'hFFFFFFFF);
        driveB(1'b1, 1'b1, 4'hF, 32'd511, 32'h5110BEEF);
        @(negedge clk); driveA(1'b1, 1'b0, 4'h0, 32'd600, 32'h0);
        driveB(1'b1, 1'b0, 4'h0, 32'd88, 32'h0);
        expectRead(0, 32'h0, 32'h0, 1'b1);
        expectRead(1, 32'h55667788, 32'h55667788, 1'b0);
        @(negedge clk); driveA(1'b1, 1'b0, 4'h0, 32'd512, 32'h0);
        driveB(1'b1, 1'b0, 4'h0, 32'd511, 32'h0);
        expectRead(0, 32'h0, 32'h0, 1'b1);
        expectRead(1, 32'h5110BEEF, 32'h5110BEEF, 1'b0);
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrList [4] = '{32'd5, 32'd7, 32'd9, 32'd2};
        logic [31:0] dataList [4] = '{32'hDEADBEEF, 32'h11BB33DD, 32'h0000BBAA, 32'h00000033};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            driveA(1'b1, 1'b0, 4'h0, addrList[i], 32'h0);
            driveB(1'b1, 1'b0, 4'h0, addrList[3-i], 32'h0);
            expectRead(0, dataList[i], dataList[i], 1'b0);
            expectRead(1, dataList[3-i], dataList[3-i], 1'b0);
        end
        @(negedge clk); idle();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        @(negedge clk); driveA(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
        driveB(1'b1, 1'b0, 4'h0, 32'd7, 32'h0);
        expectRead(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        expectRead(1, 32'h11BB33DD, 32'h11BB33DD, 1'b0);
        @(negedge clk); idle();
        @(negedge clk); rst = 1'b1;
        driveA(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
        #1;
        for (int d = 0; d < 2; d++) begin
            assertCount++;
            if (aReqReady[d] !== 1'b0 || bReqReady[d] !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL ready during reset dut%0d: got a=%b b=%b, expected 0/0", d, aReqReady[d], bReqReady[d]);
            end
        end
        @(negedge clk); rst = 1'b0; idle();
        repeat (6) @(negedge clk);
        driveA(1'b1, 1'b0, 4'h0, 32'd7, 32'h0);
        driveB(1'b1, 1'b0, 4'h0, 32'd5, 32'h0);
        expectRead(0, 32'h11BB33DD, 32'h11BB33DD, 1'b0);
        expectRead(1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        @(negedge clk); idle();
        repeat (6) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        $display("[TB] sim_ram_dp bench start");
        test_reset();
        test_basic();
        test_byte_mask();
        test_collision();
        test_read_during_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_midflight();
        for (int k = 0; k < 4; k++) begin
            assertCount++;
            if (expQ[k].size() != 0) begin
                failCount++;
                $display("[TB] FAIL %s drain: got %0d pending responses, expected 0", portName[k], expQ[k].size());
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
